// File: rtl/bitbakery_pkg.sv
// Shared state encoding for the minigame sequencer.
package bitbakery_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    INICIAL    = 3'd0,
    PREPARACAO = 3'd1,
    EXECUCAO   = 3'd2,
    FIM        = 3'd3,
    INTERVALO  = 3'd4,
    START      = 3'd5,
    FIM_JOGO   = 3'd6
  } seq_state_e;

endpackage

// File: rtl/minigame_sequencer_if.sv
// Game-channel bundle: start pulses out, done flags and scores back.
interface minigame_sequencer_if #(
  parameter int unsigned N_GAMES = 4,
  parameter int unsigned SCORE_W = 3
);
  logic [N_GAMES-1:0]         jogar;
  logic [N_GAMES-1:0]         pronto;
  logic [N_GAMES*SCORE_W-1:0] pontuacao;

  modport master (output jogar, input pronto, input pontuacao);
  modport slave  (input jogar, output pronto, output pontuacao);
endinterface

// File: rtl/seq_timer.sv
// Cycle counter: done_o asserts on the limit_i-th consecutive enabled cycle.
module seq_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         enable_i,
  input  logic [W-1:0] limit_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done_o = enable_i && !clear_i && (cnt_q == limit_i - W'(1));
endmodule

// File: rtl/minigame_sequencer.sv
// Minigame sequencer: single game or tournament, with saturating score total.
// Optional EXECUCAO watchdog enabled by defining SEQ_TIMEOUT_EN.
module minigame_sequencer
  import bitbakery_pkg::*;
#(
  parameter int unsigned N_GAMES         = 4,
  parameter int unsigned SEL_W           = 2,
  parameter int unsigned SCORE_W         = 3,
  parameter int unsigned TOTAL_W         = 8,
  parameter int unsigned INTERVAL_CYCLES = 2000,
  parameter int unsigned TIMEOUT_CYCLES  = 60000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       iniciar,
  input  logic                       dificuldade,
  input  logic                       modo_torneio,
  input  logic [SEL_W-1:0]           minigame_sel,
  input  logic [N_GAMES-1:0]         game_pronto,
  input  logic [N_GAMES*SCORE_W-1:0] game_pontuacao,
  output logic [N_GAMES-1:0]         game_jogar,
  output logic [SEL_W-1:0]           game_ativo,
  output logic                       dificuldade_out,
  output logic [2:0]                 estado,
  output logic [TOTAL_W-1:0]         pontuacao_total,
  output logic                       pontuacao_valida,
  output logic                       timeout
);
  localparam int unsigned IV_W = $clog2(INTERVAL_CYCLES + 1);

  seq_state_e         state_q, state_d;
  logic [SEL_W-1:0]   ativo_q, ativo_d;
  logic               dif_q, dif_d;
  logic               torneio_q, torneio_d;
  logic [TOTAL_W-1:0] total_q, total_d;

  logic               prep_go, pronto_act, next_game, iv_done, wd_done;
  logic               iv_clear, iv_en;
  logic [SCORE_W-1:0] score_act;
  logic [TOTAL_W:0]   sum_w;

  assign prep_go    = modo_torneio || (32'(minigame_sel) < N_GAMES);
  assign pronto_act = game_pronto[ativo_q];
  assign next_game  = torneio_q && (32'(ativo_q) < N_GAMES - 1);
  assign score_act  = game_pontuacao[ativo_q*SCORE_W +: SCORE_W];
  assign sum_w      = {1'b0, total_q} + (TOTAL_W+1)'(score_act);

  assign iv_en    = (state_q == INTERVALO);
  assign iv_clear = !iv_en;

  seq_timer #(.W(IV_W)) u_interval (
    .clk_i    (clock),
    .rst_i    (reset),
    .clear_i  (iv_clear),
    .enable_i (iv_en),
    .limit_i  (IV_W'(INTERVAL_CYCLES)),
    .done_o   (iv_done)
  );

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic wd_en, wd_clear, timeout_q;

  assign wd_en    = (state_q == EXECUCAO);
  assign wd_clear = !wd_en;

  seq_timer #(.W(WD_W)) u_watchdog (
    .clk_i    (clock),
    .rst_i    (reset),
    .clear_i  (wd_clear),
    .enable_i (wd_en),
    .limit_i  (WD_W'(TIMEOUT_CYCLES)),
    .done_o   (wd_done)
  );

  // A done flag arriving on the expiry cycle takes priority over the timeout.
  always_ff @(posedge clock) begin
    if (reset)                                    timeout_q <= 1'b0;
    else if (state_q == PREPARACAO && prep_go)    timeout_q <= 1'b0;
    else if (wd_en && !pronto_act && wd_done)     timeout_q <= 1'b1;
  end
  assign timeout = timeout_q;
`else
  assign wd_done = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) state_q <= INICIAL;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INICIAL:    if (iniciar) state_d = PREPARACAO;
      PREPARACAO: if (prep_go) state_d = INTERVALO;
      INTERVALO:  if (iv_done) state_d = START;
      START:      state_d = EXECUCAO;
      EXECUCAO:   if (pronto_act || wd_done) state_d = FIM_JOGO;
      FIM_JOGO:   state_d = next_game ? INTERVALO : FIM;
      FIM:        if (iniciar) state_d = PREPARACAO;
      default:    state_d = INICIAL;
    endcase
  end

  always_comb begin
    game_jogar       = '0;
    pontuacao_valida = 1'b0;
    case (state_q)
      START:   game_jogar = N_GAMES'(1) << ativo_q;
      FIM:     pontuacao_valida = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    ativo_d   = ativo_q;
    dif_d     = dif_q;
    torneio_d = torneio_q;
    total_d   = total_q;
    case (state_q)
      PREPARACAO: begin
        dif_d   = dificuldade;
        ativo_d = modo_torneio ? '0 : minigame_sel;
        if (prep_go) begin
          total_d   = '0;
          torneio_d = modo_torneio;
        end
      end
      EXECUCAO: if (pronto_act) total_d = sum_w[TOTAL_W] ? '1 : sum_w[TOTAL_W-1:0];
      FIM_JOGO: if (next_game) ativo_d = ativo_q + SEL_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ativo_q   <= '0;
      dif_q     <= 1'b0;
      torneio_q <= 1'b0;
      total_q   <= '0;
    end else begin
      ativo_q   <= ativo_d;
      dif_q     <= dif_d;
      torneio_q <= torneio_d;
      total_q   <= total_d;
    end
  end

  assign game_ativo      = ativo_q;
  assign dificuldade_out = dif_q;
  assign estado          = state_q;
  assign pontuacao_total = total_q;
endmodule
